// File: rtl/gpio_6502_pkg.sv
// Shared definitions for the 6502 GPIO peripheral: register offsets,
// edge-mode encodings and the address-window decode helper.
package gpio_6502_pkg;

    localparam logic [2:0] REG_OUT   = 3'd0;
    localparam logic [2:0] REG_DDR   = 3'd1;
    localparam logic [2:0] REG_PIN   = 3'd2;
    localparam logic [2:0] REG_EDGE  = 3'd3;
    localparam logic [2:0] REG_IRQEN = 3'd4;
    localparam logic [2:0] REG_MODE  = 3'd5;

    localparam logic MODE_RISE = 1'b0;
    localparam logic MODE_FALL = 1'b1;

    // True when the address falls inside the 8-byte window starting at base.
    function automatic logic addr_hit(input logic [15:0] ab, input logic [15:0] base);
        return (ab[15:3] == base[15:3]);
    endfunction

endpackage

// File: rtl/gpio_6502_debounce.sv
// Single-pin input conditioner: 2-flop synchroniser followed by a
// saturating stability counter. stable_nxt_o is the value stable_o takes on
// the next clock edge, so the parent can detect edges on that same edge.
module gpio_debounce #(
    parameter int unsigned DEBOUNCE = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic stable_o,
    output logic stable_nxt_o
);

    logic sync1_q;
    logic sync2_q;

    // Two-stage synchroniser for the asynchronous pad input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            // No filtering: the synchroniser output is the stable state.
            assign stable_o     = sync2_q;
            assign stable_nxt_o = sync1_q;
        end else begin : g_count
            localparam int CW = $clog2(DEBOUNCE + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          stable_q;
            logic          stable_d;

            // Count consecutive cycles of disagreement; accept on the last one.
            // The counter stops at CNT_LAST, so it can never wrap.
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (sync2_q == stable_q) begin
                    cnt_d = {CW{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d    = {CW{1'b0}};
                    stable_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Debounce counter and accepted state.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= {CW{1'b0}};
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable_o     = stable_q;
            assign stable_nxt_o = stable_d;
        end
    endgenerate

endmodule

// File: rtl/gpio_6502.sv
// Memory-mapped GPIO block for the 6502 bus: OUT/DDR/PIN/EDGE/IRQ_EN/MODE
// registers, per-pin debounced inputs, edge capture and a level IRQ.
module gpio_6502
    import gpio_6502_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h6000,
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned DEBOUNCE   = 1000,
    parameter bit          OUT_INVERT = 1'b1,
    parameter logic [7:0]  OE_RESET   = 8'h00
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      AB,
    input  logic [7:0]       DO,
    input  logic             WE,
    output logic [7:0]       rd_data,
    output logic             rd_hit,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q,   out_d;
    logic [WIDTH-1:0] ddr_q,   ddr_d;
    logic [WIDTH-1:0] edge_q,  edge_d;
    logic [WIDTH-1:0] irqen_q, irqen_d;
    logic [WIDTH-1:0] mode_q,  mode_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_hit_q,  rd_hit_d;
    logic             irq_q,     irq_d;

    logic             hit_s;
    logic [2:0]       off_s;
    logic             wr_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] w1c_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] stable_nxt_s;
    logic [WIDTH-1:0] pin_view_s;
    logic [7:0]       rd_word_s;
    logic             unused_do_s;

    // Only the low WIDTH data bits reach the registers.
    assign unused_do_s = ^DO;

    // Per-pin synchroniser and debouncer.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
        gpio_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_db (
            .clk         (clk),
            .reset_n     (reset_n),
            .pin_i       (pin_in[gi]),
            .stable_o    (stable_s[gi]),
            .stable_nxt_o(stable_nxt_s[gi])
        );
    end

    // Address decode for the register window.
    always_comb begin
        hit_s   = addr_hit(AB, BASE_ADDR);
        off_s   = AB[2:0];
        wr_s    = WE & hit_s;
        wdata_s = DO[WIDTH-1:0];
    end

    // Register writes; an EDGE write produces a clear mask instead of a load.
    always_comb begin
        out_d   = out_q;
        ddr_d   = ddr_q;
        irqen_d = irqen_q;
        mode_d  = mode_q;
        w1c_s   = {WIDTH{1'b0}};
        if (wr_s) begin
            case (off_s)
                REG_OUT:   out_d   = wdata_s;
                REG_DDR:   ddr_d   = wdata_s;
                REG_EDGE:  w1c_s   = wdata_s;
                REG_IRQEN: irqen_d = wdata_s;
                REG_MODE:  mode_d  = wdata_s;
                default:   w1c_s   = {WIDTH{1'b0}};
            endcase
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
    end

    // Edge capture on accepted transitions; a new capture beats a same-cycle clear.
    always_comb begin
        set_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (mode_q[i] == MODE_FALL) begin
                set_s[i] = stable_s[i] & ~stable_nxt_s[i];
            end else begin
                set_s[i] = ~stable_s[i] & stable_nxt_s[i];
            end
        end
        edge_d = (edge_q & ~w1c_s) | set_s;
        irq_d  = |(edge_q & irqen_q);
    end

    // Read mux: PIN shows OUT for output pins, the debounced level otherwise.
    always_comb begin
        pin_view_s = (ddr_q & out_q) | (~ddr_q & stable_s);
        rd_word_s  = 8'h00;
        case (off_s)
            REG_OUT:   rd_word_s[WIDTH-1:0] = out_q;
            REG_DDR:   rd_word_s[WIDTH-1:0] = ddr_q;
            REG_PIN:   rd_word_s[WIDTH-1:0] = pin_view_s;
            REG_EDGE:  rd_word_s[WIDTH-1:0] = edge_q;
            REG_IRQEN: rd_word_s[WIDTH-1:0] = irqen_q;
            REG_MODE:  rd_word_s[WIDTH-1:0] = mode_q;
            default:   rd_word_s = 8'h00;
        endcase
        if (hit_s) begin
            rd_data_d = rd_word_s;
        end else begin
            rd_data_d = 8'h00;
        end
        rd_hit_d = hit_s;
    end

    // Register bank, read pipeline and interrupt flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= {WIDTH{1'b0}};
            ddr_q     <= OE_RESET[WIDTH-1:0];
            edge_q    <= {WIDTH{1'b0}};
            irqen_q   <= {WIDTH{1'b0}};
            mode_q    <= {WIDTH{1'b0}};
            rd_data_q <= 8'h00;
            rd_hit_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            ddr_q     <= ddr_d;
            edge_q    <= edge_d;
            irqen_q   <= irqen_d;
            mode_q    <= mode_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
            irq_q     <= irq_d;
        end
    end

    assign pin_out = OUT_INVERT ? ~out_q : out_q;
    assign pin_oe  = ddr_q;
    assign rd_data = rd_data_q;
    assign rd_hit  = rd_hit_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_6502.sv
// Scoreboard bench for gpio_6502 (WIDTH=6, DEBOUNCE=4, inverted outputs).
module tb_gpio_6502;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [15:0]  AB;
    logic [7:0]   DO;
    logic         WE;
    logic [7:0]   rd_data;
    logic         rd_hit;
    logic [W-1:0] pin_in;
    logic [W-1:0] pin_out;
    logic [W-1:0] pin_oe;
    logic         irq;
    logic         chk_en;

    typedef struct {
        logic       hit;
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    gpio_6502 #(
        .BASE_ADDR (16'h6000),
        .WIDTH     (W),
        .DEBOUNCE  (4),
        .OUT_INVERT(1'b1),
        .OE_RESET  (8'h00)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .AB     (AB),
        .DO     (DO),
        .WE     (WE),
        .rd_data(rd_data),
        .rd_hit (rd_hit),
        .pin_in (pin_in),
        .pin_out(pin_out),
        .pin_oe (pin_oe),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic hit, input logic [7:0] d, input string nm);
        exp_t e;
        @(negedge clk);
        AB = a; WE = 1'b0; DO = 8'h00; chk_en = 1'b1;
        e.hit = hit; e.data = d; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        AB = a; WE = 1'b1; DO = d; chk_en = 1'b0;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            AB = 16'h0000; WE = 1'b0; DO = 8'h00; chk_en = 1'b0;
            @(posedge clk);
        end
    endtask

    // Monitor: whenever a checked read was on the bus, compare its registered response.
    initial begin : monitor
        exp_t e;
        logic armed;
        forever begin
            @(posedge clk);
            armed = chk_en;
            #1;
            if (armed === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=response required=expectation");
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_hit"}, 8'(rd_hit), 8'(e.hit));
                    chk(e.name, rd_data, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset_n = 1'b0; AB = 16'h0000; DO = 8'h00; WE = 1'b0; chk_en = 1'b0;
        pin_in = '0;
        #3;
        chk("rst_pin_out", 8'(pin_out), 8'h3F);
        chk("rst_pin_oe",  8'(pin_oe),  8'h00);
        chk("rst_irq",     8'(irq),     8'h00);
        chk("rst_rd_hit",  8'(rd_hit),  8'h00);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset values across the whole window and its neighbours.
        for (int i = 0; i < 8; i++) begin
            rd(16'h6000 + 16'(i), 1'b1, 8'h00, $sformatf("rst_reg%0d", i));
        end
        rd(16'h6008, 1'b0, 8'h00, "out_of_window_hi");
        rd(16'h5FFF, 1'b0, 8'h00, "out_of_window_lo");

        // Output path.
        wr(16'h6001, 8'h3F);
        wr(16'h6000, 8'h15);
        #1;
        chk("pin_out_inv", 8'(pin_out), 8'h2A);
        chk("pin_oe_ddr",  8'(pin_oe),  8'h3F);
        rd(16'h6002, 1'b1, 8'h15, "pin_reads_out");
        rd(16'h6000, 1'b1, 8'h15, "out_rb");
        rd(16'h6001, 1'b1, 8'h3F, "ddr_rb");
        wr(16'h6000, 8'hFF);
        rd(16'h6000, 1'b1, 8'h3F, "out_upper_masked");
        wr(16'h6006, 8'hAA);
        rd(16'h6006, 1'b1, 8'h00, "reg6_zero");
        rd(16'h6007, 1'b1, 8'h00, "reg7_zero");
        wr(16'h6000, 8'h00);
        wr(16'h6001, 8'h00);
        #1 chk("pin_oe_cleared", 8'(pin_oe), 8'h00);

        // A 3-cycle glitch must be rejected.
        idle(2);
        #1 pin_in[0] = 1'b1;
        idle(3);
        #1 pin_in[0] = 1'b0;
        idle(10);
        rd(16'h6002, 1'b1, 8'h00, "glitch_pin");
        rd(16'h6003, 1'b1, 8'h00, "glitch_edge");

        // Held input accepted exactly 2+DEBOUNCE cycles later.
        #1 pin_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            rd(16'h6002, 1'b1, (k >= 7) ? 8'h01 : 8'h00, $sformatf("lat%0d", k));
        end
        idle(6);
        rd(16'h6003, 1'b1, 8'h01, "edge_rise");

        // Interrupt generation and W1C.
        wr(16'h6004, 8'h01);
        #1 chk("irq_lag", 8'(irq), 8'h00);
        idle(1);
        #1 chk("irq_set", 8'(irq), 8'h01);
        wr(16'h6003, 8'h01);
        #1 chk("irq_hold", 8'(irq), 8'h01);
        idle(1);
        #1 chk("irq_clear", 8'(irq), 8'h00);
        rd(16'h6003, 1'b1, 8'h00, "edge_w1c");

        // Falling-edge mode on pin 1.
        wr(16'h6005, 8'h02);
        rd(16'h6003, 1'b1, 8'h00, "mode_no_set");
        rd(16'h6005, 1'b1, 8'h02, "mode_rb");
        #1 pin_in[1] = 1'b1;
        idle(10);
        rd(16'h6003, 1'b1, 8'h00, "fall_mode_rise");
        rd(16'h6002, 1'b1, 8'h03, "pin_both_high");
        #1 pin_in[1] = 1'b0;
        idle(10);
        rd(16'h6003, 1'b1, 8'h02, "fall_edge");
        #1 chk("irq_masked", 8'(irq), 8'h00);
        wr(16'h6003, 8'h00);
        rd(16'h6003, 1'b1, 8'h02, "w1c_zero");
        wr(16'h6003, 8'h02);
        rd(16'h6003, 1'b1, 8'h00, "w1c_bit1");

        // New capture on the same edge as a W1C of that bit.
        #1 pin_in[1] = 1'b1;
        idle(10);
        rd(16'h6003, 1'b1, 8'h00, "fall_mode_rise2");
        #1 pin_in[1] = 1'b0;
        idle(5);
        wr(16'h6003, 8'h02);
        rd(16'h6003, 1'b1, 8'h02, "set_beats_w1c");

        // Asynchronous reset mid-operation.
        wr(16'h6004, 8'h02);
        wr(16'h6001, 8'h30);
        wr(16'h6000, 8'h30);
        #1 chk("irq_pre_rst", 8'(irq), 8'h01);
        pin_in[2] = 1'b1;
        idle(3);
        rd(16'h6001, 1'b1, 8'h30, "pre_rst_ddr");
        @(negedge clk);
        chk_en = 1'b0;
        chk("pre_rst_pin_out", 8'(pin_out), 8'h0F);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_irq",     8'(irq),     8'h00);
        chk("arst_rd_hit",  8'(rd_hit),  8'h00);
        chk("arst_rd_data", rd_data,     8'h00);
        chk("arst_pin_out", 8'(pin_out), 8'h3F);
        chk("arst_pin_oe",  8'(pin_oe),  8'h00);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            rd(16'h6002, 1'b1, (k >= 7) ? 8'h05 : 8'h00, $sformatf("post_rst_lat%0d", k));
        end
        idle(2);
        rd(16'h6003, 1'b1, 8'h05, "edge_after_rst");
        #1 chk("irq_after_rst", 8'(irq), 8'h00);
        rd(16'h6004, 1'b1, 8'h00, "irqen_after_rst");

        idle(2);
        chk("sb_drain", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_6502.md
Name: gpio_6502

Overview:
Parametrised memory-mapped GPIO peripheral for the 6502 CPU bus. It replaces the hard-wired LED latch and button read with a small register bank of up to 8 pins. Each pin has direction control, a 2-flop synchroniser, a debouncer, edge capture and an interrupt request. It sits beside the ROM in the top-level address decode, and its read data is muxed onto the CPU DI bus.

Parameters:
BASE_ADDR, 16'h6000, base of the 8-byte register window; BASE_ADDR[2:0] must be 0
WIDTH, 6, number of pins, legal range 1..8
DEBOUNCE, 16'd1000, stable cycles required before an input change is accepted; 0 = bypass (synchroniser only)
OUT_INVERT, 1'b1, 1 = pin_out driven inverted (active-low LEDs)
OE_RESET, 8'h00, reset value of DDR[WIDTH-1:0]

Ports:
clk  in  1  system clock, same as CPU
reset_n  in  1  asynchronous active-low reset
AB  in  16  CPU address bus
DO  in  8  CPU write data
WE  in  1  CPU write enable
rd_data  out  8  registered read data, valid the cycle after the address
rd_hit  out  1  registered; 1 when the previous-cycle AB was inside the window; top-level selects rd_data onto DI
pin_in  in  WIDTH  raw asynchronous pad inputs (buttons)
pin_out  out  WIDTH  output data (after OUT_INVERT)
pin_oe  out  WIDTH  output enable = DDR
irq  out  1  registered level interrupt request, active high

Behaviour:
- Reset is asynchronous, active-low, and may arrive mid-operation. It clears OUT, EDGE, IRQ_EN, EDGE_MODE, rd_data, rd_hit, irq, synchronisers and debounce counters to 0, and sets DDR=OE_RESET. The stable debounced state resets to 0.
- pin_out after reset is all-0s, or all-1s when OUT_INVERT=1.
- Decode: hit = (AB[15:3] == BASE_ADDR[15:3]); register offset = AB[2:0].
- Register map (bits above WIDTH-1 read 0 and ignore writes):
  - 0 OUT: rw
  - 1 DDR: rw, 1 = output
  - 2 PIN: ro, reads the debounced state; for pins with DDR=1 it reads the OUT bit instead
  - 3 EDGE: read flags; write-1-to-clear
  - 4 IRQ_EN: rw
  - 5 EDGE_MODE: rw, per pin, 0 = rising, 1 = falling
  - 6, 7: read 8'h00, writes ignored
- Writes: when WE && hit, the register updates on that clk edge and is visible on the next read.
- Reads: every cycle rd_data <= hit ? reg[offset] : 8'h00 and rd_hit <= hit, giving 1-cycle latency. Reads have no side effects; EDGE is not read-to-clear.
- Input path: 2-flop synchroniser, then the debouncer.
- Debouncer, per pin:
  - If sync == stable, the counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE-1, stable <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE cycles is never accepted.
  - Counter width is $clog2(DEBOUNCE+1) and must not wrap.
  - Total input latency: 2 + DEBOUNCE cycles.
- Edge capture: a stable 0->1 with mode 0, or 1->0 with mode 1, sets EDGE[i] on the same edge that stable updates.
- Simultaneous set and W1C on the same bit: the set wins and the flag stays 1.
- Flags are captured regardless of DDR and IRQ_EN.
- irq <= |(EDGE & IRQ_EN), registered, one cycle after the flag or enable changes. It remains asserted until software clears the flags or the enables.
- Changing EDGE_MODE does not itself set flags.

Decomposition:
- Shared package gpio_6502_pkg holds:
  - register offsets: REG_OUT=0, REG_DDR=1, REG_PIN=2, REG_EDGE=3, REG_IRQEN=4, REG_MODE=5
  - MODE_RISE=0, MODE_FALL=1
- One natural sub-module, gpio_debounce: a single-pin synchroniser plus debounce counter, parameter DEBOUNCE, output stable. It is instantiated WIDTH times in a generate loop. Register bank, decode and edge/IRQ logic stay in gpio_6502.

Test Plan:
- Reset, then read offsets 0..7: rd_data=00 except DDR=OE_RESET; with OUT_INVERT=1, pin_out=6'h3F; irq=0; rd_hit=1 only for AB in 6000..6007, and 0 for AB=6008.
- Write DDR=0x3F, then OUT=0x15 at 6000: pin_out=0x2A (inverted), pin_oe=0x3F; read 6002 returns 0x15 one cycle after the address.
- DEBOUNCE=4, DDR=0: pulse pin_in[0] high for 3 cycles -> PIN stays 0, no EDGE. Hold 10 cycles -> PIN[0]=1 exactly 6 cycles after the rise; EDGE=0x01.
- IRQ_EN=0x01 with EDGE[0] set -> irq=1 next cycle. Write 0x01 to 6003 -> EDGE=0, irq=0 one cycle later. Write 0x00 to 6003 -> no effect.
- EDGE_MODE[1]=1: falling edge on pin 1 sets EDGE[1], rising does not. A W1C of bit 1 in the same cycle as a new capture leaves EDGE[1]=1.
- Assert reset_n low asynchronously while irq=1 and a debounce count is in progress: all outputs clear immediately without a clk edge. After release, the held input is re-debounced for the full DEBOUNCE count.
